deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel stage directly downstream of the team's serializer. It consumes the MSB-first bit stream (`ser_data_o` / `ser_data_val_o`) and repacks it into DATA_W-bit words. Runs of fewer than DATA_W bits are flushed after a programmable idle timeout, with a bit count in the serializer's `data_mod` encoding. The deserializer has no backpressure, matching the serializer it consumes from.

## Interface
- `DATA_W`, default 16: output word width; MOD_W = $clog2(DATA_W).
- `IDLE_TIMEOUT`, default 4: consecutive idle cycles (`data_val_i` low) that flush a partial word; legal range ≥ 1.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `srst_i`  in  1  synchronous, active-low reset (`srst_i == 0` resets at the next rising edge).
- `data_i`  in  1  serial bit; MSB of each word arrives first.
- `data_val_i`  in  1  `data_i` is valid this cycle.
- `deser_data_o`  out  DATA_W  assembled word, left-aligned; unfilled LSBs are 0.
- `deser_data_mod_o`  out  MOD_W  number of valid bits; 0 means a full DATA_W-bit word.
- `deser_data_val_o`  out  1  one-cycle pulse qualifying `deser_data_o` and `deser_data_mod_o`.

## Operation
- **Internal state:**
  - shift register `shreg` [DATA_W-1:0];
  - bit counter `cnt` (0..DATA_W-1, width MOD_W);
  - idle counter `idle` (0..IDLE_TIMEOUT-1).
- **Two states:**
  - EMPTY (`cnt == 0`): idle counter held at 0; no flush possible.
  - COLLECT (`cnt > 0`).
- **Each cycle with `data_val_i = 1`:**
  - `shreg` shifts left and `data_i` enters the LSB.
  - `idle` clears to 0.
  - If `cnt == DATA_W-1`, the word completes:
    - `deser_data_o` = {`shreg`[DATA_W-2:0], `data_i`};
    - `deser_data_mod_o` = 0;
    - `deser_data_val_o` = 1;
    - `cnt` returns to 0 (EMPTY) and `shreg` clears.
  - Otherwise `cnt` increments.
- **Each cycle with `data_val_i = 0` in COLLECT:**
  - If `idle == IDLE_TIMEOUT-1`, flush:
    - `deser_data_o` = `shreg` << (DATA_W - `cnt`), i.e. the received bits left-aligned with zero fill;
    - `deser_data_mod_o` = `cnt`;
    - `deser_data_val_o` = 1;
    - `cnt`, `idle` and `shreg` return to 0.
  - Otherwise `idle` increments.
- **Outputs between pulses:**
  - `deser_data_val_o` is 0 in every cycle not listed above.
  - `deser_data_o` / `deser_data_mod_o` hold their last pulsed values.
- **Partial counts:** 1..DATA_W-1 are all legal. Counts of 1 and 2 are emitted even though the serializer never produces them.
- **Arithmetic:** counters never wrap; `cnt` saturates by design at DATA_W-1 via the completion rule.

## Timing
- **Reset values:** `deser_data_o = 0`, `deser_data_mod_o = 0`, `deser_data_val_o = 0`; internal `cnt = 0`, `idle = 0`, `shreg = 0`.
- **Full-word latency:** with the last bit sampled on edge t, `deser_data_val_o` is high for the cycle following edge t (one registered stage).
- **Flush latency:** with the last bit on edge t and no further valid bits, the pulse follows edge t + IDLE_TIMEOUT.
- **Back-to-back words:** a bit on the cycle right after completion starts the next word. Continuous streaming yields one pulse every DATA_W cycles with no lost bits.
- **Gaps shorter than IDLE_TIMEOUT** inside a word are absorbed; the word continues.
- **Valid bit vs timeout:** a valid bit in the cycle that would otherwise be the timeout cycle cancels the flush. The bit is appended and `idle` clears; a valid input always wins over the timeout.
- **Reset mid-word:** the partial word is discarded with no pulse, and any pulse in flight is dropped. The first valid bit after reset release is the MSB of a new word.
- **Reset priority:** reset overrides all other activity in the same cycle.

## Test plan
- **Full word:** stream 16'hA5C3 MSB-first, continuous -> one pulse, `deser_data_o` = 16'hA5C3, `deser_data_mod_o` = 0, one cycle after the 16th bit.
- **Back-to-back:** 16'h1234 then 16'hFFFF, no gap -> two pulses exactly 16 cycles apart with the correct values; `deser_data_val_o` low in between.
- **Absorbed gaps:** 16'h8001 with a 3-cycle gap after bit 7 (IDLE_TIMEOUT = 4) -> a single pulse, 16'h8001, mod 0, no flush.
- **Partial flush:** bits 1,0,1,1,0 then idle -> pulse 4 cycles after the last bit, `deser_data_o` = 16'hB000, `deser_data_mod_o` = 5.
- **Single-bit flush and timeout race:**
  - 1 bit (1) then idle -> 16'h8000, mod 1.
  - Separately, a bit arriving on the 4th idle cycle -> no flush; the word continues.
- **Reset mid-word:** 9 bits, then `srst_i` = 0 for 1 cycle, then a full 16'h0F0F -> no pulse for the aborted bits; a single pulse of 16'h0F0F, mod 0.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel repacker for the MSB-first serializer stream.
// Emits full words, or flushes partial words after an idle timeout.
module deserializer #(
    parameter int DATA_W       = 16,
    parameter int IDLE_TIMEOUT = 4,
    parameter int MOD_W        = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o
);

    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [MOD_W-1:0] CNT_LAST  = MOD_W'(DATA_W - 1);
    localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [MOD_W:0]   FULL_W    = (MOD_W + 1)'(DATA_W);

    typedef enum logic {
        EMPTY   = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [MOD_W-1:0]  cnt;
    logic [IW-1:0]     idle;
    logic [MOD_W:0]    flush_sh;

    // Distance that left-aligns the cnt bits held in the LSBs of shreg.
    always_comb begin
        flush_sh = FULL_W - {1'b0, cnt};
    end

    // Collect bits; emit on completion or on idle timeout.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state            <= EMPTY;
            shreg            <= '0;
            cnt              <= '0;
            idle             <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            if (data_val_i) begin
                idle <= '0;
                if (cnt == CNT_LAST) begin
                    deser_data_o     <= {shreg[DATA_W-2:0], data_i};
                    deser_data_mod_o <= '0;
                    deser_data_val_o <= 1'b1;
                    shreg            <= '0;
                    cnt              <= '0;
                    state            <= EMPTY;
                end else begin
                    shreg <= {shreg[DATA_W-2:0], data_i};
                    cnt   <= cnt + MOD_W'(1);
                    state <= COLLECT;
                end
            end else begin
                case (state)
                    COLLECT: begin
                        if (idle == IDLE_LAST) begin
                            deser_data_o     <= shreg << flush_sh;
                            deser_data_mod_o <= cnt;
                            deser_data_val_o <= 1'b1;
                            shreg            <= '0;
                            cnt              <= '0;
                            idle             <= '0;
                            state            <= EMPTY;
                        end else begin
                            idle <= idle + IW'(1);
                        end
                    end
                    default: begin
                        idle <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: directed streams, queued
// expectations checked by an independent output monitor.
module tb_deserializer;

    localparam int DW = 16;
    localparam int MW = 4;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b0;
    logic          data_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic [DW-1:0] deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;

    typedef struct {
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        int            c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    deserializer #(.DATA_W(DW), .IDLE_TIMEOUT(TO)) dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (deser_data_val_o) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse cycle=%0d data=%0h mod=%0d",
                         cyc, deser_data_o, deser_data_mod_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_data", int'(deser_data_o), int'(e.d));
                chk("pulse_mod", int'(deser_data_mod_o), int'(e.m));
                chk("pulse_cycle", cyc, e.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_val_i = 1'b1;
        data_i     = b;
        tick();
        data_val_i = 1'b0;
        data_i     = 1'b0;
    endtask

    task automatic idle_n(input int n);
        data_val_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [MW-1:0] m,
                        input int c);
        exp_t e;
        e.d = d;
        e.m = m;
        e.c = c;
        q.push_back(e);
    endtask

    // Full word, MSB first, optional gap of glen after gpos bits.
    task automatic send_word(input logic [DW-1:0] w, input int gpos,
                             input int glen, input logic [DW-1:0] ew);
        for (int i = 0; i < DW; i++) begin
            if (i == gpos) idle_n(glen);
            send_bit(w[DW-1-i]);
        end
        push(ew, '0, cyc);
    endtask

    initial begin
        logic [DW-1:0] w;
        repeat (3) tick();
        chk("reset_data", int'(deser_data_o), 0);
        chk("reset_mod", int'(deser_data_mod_o), 0);
        chk("reset_val", int'(deser_data_val_o), 0);
        srst_i = 1'b1;
        idle_n(2);

        send_word(16'hA5C3, -1, 0, 16'hA5C3);
        idle_n(3);

        send_word(16'h1234, -1, 0, 16'h1234);
        send_word(16'hFFFF, -1, 0, 16'hFFFF);
        idle_n(3);

        send_word(16'h8001, 7, 3, 16'h8001);
        idle_n(6);

        w = 16'hB000;
        for (int i = 0; i < 5; i++) send_bit(w[DW-1-i]);
        push(16'hB000, 4'd5, cyc + TO);
        idle_n(TO + 3);

        send_bit(1'b1);
        push(16'h8000, 4'd1, cyc + TO);
        idle_n(TO + 3);

        send_word(16'hC3A5, 1, TO - 1, 16'hC3A5);
        idle_n(6);

        w = 16'h0123;
        for (int i = 0; i < 15; i++) send_bit(w[DW-1-i]);
        push(16'h0122, 4'd15, cyc + TO);
        idle_n(TO + 3);

        w = 16'hFFFF;
        for (int i = 0; i < 9; i++) send_bit(w[i]);
        srst_i = 1'b0;
        tick();
        srst_i = 1'b1;
        send_word(16'h0F0F, -1, 0, 16'h0F0F);
        idle_n(TO + 4);

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
